// File: rtl/alu_ram_sequencer.sv
// Instruction sequencer feeding the register-file/ALU top level: LOAD writes, ALU read/settle/capture/writeback/respond.
// Optional retired-instruction counter enabled by defining SEQ_PERF_CNT_EN.
module alu_ram_sequencer #(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned INSTR_W = 18
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [7:0]         data,
    output logic               write_enable,
    output logic [3:0]         addr_write,
    output logic [3:0]         addr0,
    output logic [3:0]         addr1,
    output logic [2:0]         select,
    input  logic [7:0]         result,
    input  logic               zero_flag,
    input  logic               carry_flag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [7:0]         rsp_result,
    output logic               rsp_zero,
    output logic               rsp_carry,
    output logic               illegal,
    output logic [15:0]        instr_count
);

    localparam int unsigned WAIT_W = 4;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned OP_W   = 3;

    localparam logic [1:0] K_LOAD = 2'b00;
    localparam logic [1:0] K_ALU  = 2'b01;
    localparam logic [1:0] K_NOP  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT,
        S_CAPTURE,
        S_WB,
        S_RESP
    } state_t;

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [OP_W-1:0]     op_q;
    logic [REG_W-1:0]    rd_q;
    logic [REG_W-1:0]    ra_q;
    logic [REG_W-1:0]    rb_q;

    // Bit 12 of the encoding is reserved and intentionally ignored.
    logic unused_c;
    assign unused_c = instr[12];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            op_q         <= '0;
            rd_q         <= '0;
            ra_q         <= '0;
            rb_q         <= '0;
            instr_ready  <= 1'b1;
            data         <= '0;
            write_enable <= 1'b0;
            addr_write   <= '0;
            addr0        <= '0;
            addr1        <= '0;
            select       <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_carry    <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        case (instr[17:16])
                            K_LOAD: begin
                                write_enable <= 1'b1;
                                data         <= instr[7:0];
                                addr_write   <= instr[11:8];
                                instr_ready  <= 1'b0;
                                state        <= S_WRITE;
                            end
                            K_ALU: begin
                                op_q        <= instr[15:13];
                                rd_q        <= instr[11:8];
                                ra_q        <= instr[7:4];
                                rb_q        <= instr[3:0];
                                instr_ready <= 1'b0;
                                state       <= S_READ;
                            end
                            K_NOP: begin
                                state <= S_IDLE;
                            end
                            default: begin
                                illegal <= 1'b1;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    write_enable <= 1'b0;
                    instr_ready  <= 1'b1;
                    state        <= S_IDLE;
                end
                S_READ: begin
                    addr0    <= ra_q;
                    addr1    <= rb_q;
                    select   <= op_q;
                    wait_cnt <= WAIT_W'(ALU_LAT - 1);
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= S_CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                // Result is captured once; writeback and response both use the captured copy.
                S_CAPTURE: begin
                    rsp_result   <= result;
                    rsp_zero     <= zero_flag;
                    rsp_carry    <= carry_flag;
                    write_enable <= 1'b1;
                    data         <= result;
                    addr_write   <= rd_q;
                    state        <= S_WB;
                end
                S_WB: begin
                    write_enable <= 1'b0;
                    rsp_valid    <= 1'b1;
                    state        <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        instr_ready <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    write_enable <= 1'b0;
                    rsp_valid    <= 1'b0;
                    instr_ready  <= 1'b1;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_PERF_CNT_EN
    // Retire points: NOP at acceptance, LOAD in WRITE, ALU at the response handshake.
    logic        retire_c;
    logic [15:0] count_q;

    assign retire_c = ((state == S_IDLE) && instr_valid && (instr[17:16] == K_NOP))
                    || (state == S_WRITE)
                    || ((state == S_RESP) && rsp_ready);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (retire_c && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign instr_count = count_q;
`else
    assign instr_count = '0;
`endif

endmodule
